// File: rtl/fib_pkg.sv
// +----------------------------------------------------------------------------+
// | Module      : fib_pkg                                                      |
// | Description : Shared definitions for the second-order recurrence engine:  |
// |               seed-mode encodings, FSM state type and Lucas seed values.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

package fib_pkg;

   // Seed-mode encodings for i_mode; 2'b11 is reserved and decodes as Fibonacci.
   localparam logic [1:0] FIB_MODE_FIB    = 2'b00;
   localparam logic [1:0] FIB_MODE_LUCAS  = 2'b01;
   localparam logic [1:0] FIB_MODE_CUSTOM = 2'b10;

   // Lucas sequence seeds: L(0) = 2, L(1) = 1.
   localparam int LUCAS_T0 = 2;
   localparam int LUCAS_T1 = 1;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } fib_state_t;

endpackage : fib_pkg

`default_nettype wire

// File: rtl/fib_sat_adder.sv
// +----------------------------------------------------------------------------+
// | Module      : fib_sat_adder                                                |
// | Description : WIDTH-bit adder with carry out and optional clamp to         |
// |               all-ones when the sum does not fit.                          |
// | Ports       : i_a, i_b  - addends                                          |
// |               o_sum     - wrapped or clamped sum                           |
// |               o_carry   - carry out of the WIDTH-bit add                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fib_sat_adder
   import fib_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry
);

   logic [WIDTH:0] w_full;

   assign w_full  = {1'b0, i_a} + {1'b0, i_b};
   assign o_carry = w_full[WIDTH];

   generate
      if (SATURATE) begin : g_sat
         assign o_sum = o_carry ? {WIDTH{1'b1}} : w_full[WIDTH-1:0];
      end else begin : g_wrap
         assign o_sum = w_full[WIDTH-1:0];
      end
   endgenerate

endmodule : fib_sat_adder

`default_nettype wire

// File: rtl/fib_seq_engine.sv
// +----------------------------------------------------------------------------+
// | Module      : fib_seq_engine                                               |
// | Description : Second-order recurrence engine T(k) = T(k-1) + T(k-2) with   |
// |               selectable seeds, overflow detection, abort and a per-term   |
// |               streaming view.                                              |
// | Ports       : i_clk, i_reset_n (async, active low)                         |
// |               i_stb   - start request (IDLE only)                          |
// |               i_abort - cancel running computation                         |
// |               i_mode  - 00 Fib, 01 Lucas, 10 custom, 11 -> Fib             |
// |               i_seed0/i_seed1 - custom seeds, i_n - requested index        |
// |               o_busy, o_done (1-cycle pulse), o_fib, o_overflow            |
// |               o_term_valid/o_term - streaming view of T(0)..T(n)           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fib_seq_engine
   import fib_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int N_WIDTH  = 8,
   parameter bit SATURATE = 1'b0
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_stb,
   input  logic               i_abort,
   input  logic [1:0]         i_mode,
   input  logic [WIDTH-1:0]   i_seed0,
   input  logic [WIDTH-1:0]   i_seed1,
   input  logic [N_WIDTH-1:0] i_n,
   output logic               o_busy,
   output logic               o_done,
   output logic [WIDTH-1:0]   o_fib,
   output logic               o_overflow,
   output logic               o_term_valid,
   output logic [WIDTH-1:0]   o_term
);

   fib_state_t         r_state;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [N_WIDTH-1:0] r_cnt;
   logic               r_ovf_sticky;

   logic [WIDTH-1:0]   w_seed0;
   logic [WIDTH-1:0]   w_seed1;
   logic [WIDTH-1:0]   w_sum;
   logic               w_carry;
   logic               w_ovf_hit;

   always_comb begin
      w_seed0 = '0;
      w_seed1 = WIDTH'(1);
      case (i_mode)
         FIB_MODE_LUCAS: begin
            w_seed0 = WIDTH'(LUCAS_T0);
            w_seed1 = WIDTH'(LUCAS_T1);
         end
         FIB_MODE_CUSTOM: begin
            w_seed0 = i_seed0;
            w_seed1 = i_seed1;
         end
         default: begin
            w_seed0 = '0;
            w_seed1 = WIDTH'(1);
         end
      endcase
   end

   fib_sat_adder #(
      .WIDTH    (WIDTH),
      .SATURATE (SATURATE)
   ) u_add (
      .i_a     (r_a),
      .i_b     (r_b),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   // With a = T(k) the sum is T(k+2) and cnt = n-k, so the new term lies
   // within the requested range only while cnt >= 2. The carry into T(n+1)
   // is computed at cnt == 1 and must not raise the flag.
   assign w_ovf_hit = w_carry && (r_cnt > N_WIDTH'(1));

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= ST_IDLE;
         r_a          <= '0;
         r_b          <= '0;
         r_cnt        <= '0;
         r_ovf_sticky <= 1'b0;
         o_done       <= 1'b0;
         o_fib        <= '0;
         o_overflow   <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_stb) begin
                  r_a          <= w_seed0;
                  r_b          <= w_seed1;
                  r_cnt        <= i_n;
                  r_ovf_sticky <= 1'b0;
                  o_overflow   <= 1'b0;
                  r_state      <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Abort takes priority over a completion in the same cycle.
               if (i_abort) begin
                  r_state <= ST_IDLE;
               end else if (r_cnt == '0) begin
                  o_fib      <= r_a;
                  o_done     <= 1'b1;
                  o_overflow <= r_ovf_sticky;
                  r_state    <= ST_IDLE;
               end else begin
                  r_a   <= r_b;
                  r_b   <= w_sum;
                  r_cnt <= r_cnt - 1'b1;
                  if (w_ovf_hit) begin
                     r_ovf_sticky <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_busy       = (r_state == ST_RUN);
   assign o_term_valid = (r_state == ST_RUN);
   assign o_term       = r_a;

endmodule : fib_seq_engine

`default_nettype wire

// File: tb/tb_fib_seq_engine.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_fib_seq_engine                                            |
// | Description : Scoreboard bench for fib_seq_engine; a wrapping and a        |
// |               saturating instance share one stimulus stream.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fib_seq_engine;

   logic       clk;
   logic       rst_n;
   logic       stb;
   logic       abort;
   logic [1:0] mode;
   logic [7:0] seed0;
   logic [7:0] seed1;
   logic [7:0] n;

   logic       busy,  done,  ovf,  tv;
   logic [7:0] fib,   term;
   logic       busy_s, done_s, ovf_s, tv_s;
   logic [7:0] fib_s,  term_s;

   typedef struct {
      logic [7:0] fib;
      logic [7:0] fib_sat;
      logic       ovf;
      int         cyc;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] term_q[$];
   exp_t       e_mon;
   bit         term_en;
   int         cyc;
   int         n_checks;
   int         n_pass;

   fib_seq_engine #(.WIDTH(8), .N_WIDTH(8), .SATURATE(1'b0)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_abort(abort), .i_mode(mode),
      .i_seed0(seed0), .i_seed1(seed1), .i_n(n),
      .o_busy(busy), .o_done(done), .o_fib(fib), .o_overflow(ovf),
      .o_term_valid(tv), .o_term(term)
   );

   fib_seq_engine #(.WIDTH(8), .N_WIDTH(8), .SATURATE(1'b1)) dut_s (
      .i_clk(clk), .i_reset_n(rst_n), .i_stb(stb), .i_abort(abort), .i_mode(mode),
      .i_seed0(seed0), .i_seed1(seed1), .i_n(n),
      .o_busy(busy_s), .o_done(done_s), .o_fib(fib_s), .o_overflow(ovf_s),
      .o_term_valid(tv_s), .o_term(term_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
   endtask

   // Monitor: pops expected results whenever a DUT presents o_done or a term.
   always @(negedge clk) begin
      if (rst_n) begin
         if (term_en && tv) begin
            if (term_q.size() == 0) check("term_extra", 32'd1, 32'd0);
            else check("term", {24'd0, term}, {24'd0, term_q.pop_front()});
         end
         if (done || done_s) begin
            if (exp_q.size() == 0) begin
               check("spurious_done", {30'd0, done, done_s}, 32'd0);
            end else begin
               e_mon = exp_q.pop_front();
               check("done_pair", {30'd0, done, done_s}, 32'd3);
               check("fib",       {24'd0, fib},   {24'd0, e_mon.fib});
               check("fib_sat",   {24'd0, fib_s}, {24'd0, e_mon.fib_sat});
               check("ovf",       {31'd0, ovf},   {31'd0, e_mon.ovf});
               check("ovf_sat",   {31'd0, ovf_s}, {31'd0, e_mon.ovf});
               check("latency",   cyc, e_mon.cyc);
               check("busy_in_done", {30'd0, busy, busy_s}, 32'd0);
            end
         end
      end
   end

   task automatic start(input logic [1:0] m, input logic [7:0] s0, input logic [7:0] s1,
                        input logic [7:0] nn, input logic [7:0] ef, input logic [7:0] efs,
                        input logic eo, input bit push);
      @(negedge clk);
      mode = m; seed0 = s0; seed1 = s1; n = nn; stb = 1'b1;
      // o_done appears after edge E(n+1), where E0 is the next edge.
      if (push) exp_q.push_back('{fib: ef, fib_sat: efs, ovf: eo, cyc: cyc + int'(nn) + 2});
      @(negedge clk);
      stb = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int k = 0;
      while (exp_q.size() != 0 && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      check("drain_timeout", exp_q.size(), 32'd0);
      @(negedge clk);
   endtask

   // Abort at the 3rd RUN cycle; optional ignored strobe in the 2nd.
   task automatic abort_run(input logic [7:0] nn, input bit pulse,
                            input logic [7:0] hold, input logic [7:0] hold_s);
      start(2'b00, 8'd0, 8'd0, nn, 8'd0, 8'd0, 1'b0, 1'b0);
      @(negedge clk);
      stb = pulse;
      @(negedge clk);
      stb = 1'b0;
      check("busy_before_abort", {30'd0, busy, busy_s}, 32'd3);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("busy_after_abort", {30'd0, busy, busy_s}, 32'd0);
      check("fib_held",   {24'd0, fib},   {24'd0, hold});
      check("fib_s_held", {24'd0, fib_s}, {24'd0, hold_s});
      repeat (25) @(negedge clk);
   endtask

   initial begin
      n_checks = 0; n_pass = 0; cyc = 0; term_en = 1'b0;
      rst_n = 1'b0; stb = 1'b0; abort = 1'b0; mode = 2'b00;
      seed0 = 8'd0; seed1 = 8'd0; n = 8'd0;
      #2;
      check("reset_outputs", {8'd0, busy, done, fib, ovf, tv, term},       32'd0);
      check("reset_outputs_s", {8'd0, busy_s, done_s, fib_s, ovf_s, tv_s, term_s}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Fibonacci n=10 with full term stream.
      term_en = 1'b1;
      begin
         logic [7:0] terms [11] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8,
                                    8'd13, 8'd21, 8'd34, 8'd55};
         foreach (terms[i]) term_q.push_back(terms[i]);
      end
      start(2'b00, 8'd0, 8'd0, 8'd10, 8'd55, 8'd55, 1'b0, 1'b1);
      drain(40);
      term_en = 1'b0;
      check("term_stream_complete", term_q.size(), 32'd0);
      term_q.delete();

      // Overflow boundary.
      start(2'b00, 8'd0, 8'd0, 8'd13, 8'd233, 8'd233, 1'b0, 1'b1);
      drain(40);
      start(2'b00, 8'd0, 8'd0, 8'd14, 8'd121, 8'd255, 1'b1, 1'b1);
      drain(40);

      // Lucas and reserved mode.
      start(2'b01, 8'd0, 8'd0, 8'd5, 8'd11, 8'd11, 1'b0, 1'b1);
      drain(40);
      start(2'b11, 8'd9, 8'd9, 8'd5, 8'd5, 8'd5, 1'b0, 1'b1);
      drain(40);

      // Custom seeds 3/4, including changes while running.
      start(2'b10, 8'd3, 8'd4, 8'd0, 8'd3, 8'd3, 1'b0, 1'b1);
      drain(40);
      start(2'b10, 8'd3, 8'd4, 8'd1, 8'd4, 8'd4, 1'b0, 1'b1);
      drain(40);
      start(2'b10, 8'd3, 8'd4, 8'd5, 8'd29, 8'd29, 1'b0, 1'b1);
      seed0 = 8'd100; seed1 = 8'd200; mode = 2'b00; n = 8'd1;
      drain(40);

      // Abort in a long run after a 55 result; strobe in RUN ignored.
      start(2'b00, 8'd0, 8'd0, 8'd10, 8'd55, 8'd55, 1'b0, 1'b1);
      drain(40);
      abort_run(8'd20, 1'b1, 8'd55, 8'd55);
      start(2'b00, 8'd0, 8'd0, 8'd7, 8'd13, 8'd13, 1'b0, 1'b1);
      drain(40);

      // Abort coinciding with the cnt==0 completion cycle (n=2).
      abort_run(8'd2, 1'b0, 8'd13, 8'd13);

      // Asynchronous reset between edges mid-run.
      start(2'b00, 8'd0, 8'd0, 8'd20, 8'd0, 8'd0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset", {8'd0, busy, done, fib, ovf, tv, term}, 32'd0);
      check("async_reset_s", {8'd0, busy_s, done_s, fib_s, ovf_s, tv_s, term_s}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      check("idle_after_reset", {30'd0, busy, busy_s}, 32'd0);
      check("queue_empty_end", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_fib_seq_engine

`default_nettype wire
